// File: rtl/nxm_scan_datapath.sv
// nxm_scan_datapath
//   Datapath partner of the NxM bolometer-matrix scan FSM. It executes the
//   FSM's row/column counter opcodes, runs the settle and LED-display timers,
//   decodes one-hot row/column mux selects, captures each ADC conversion into
//   a per-pixel buffer with registered readback, and drives the LED bank.
//
// Ports
//   clk_i        system clock
//   rst_i        asynchronous, active-high reset
//   oprow_i      row opcode    : 00 clear, 01 hold, 10 increment, 11 hold
//   opcol_i      column opcode : same encoding
//   enset_i      settle-timer enable
//   enleds_i     LED-timer enable, also gates the LED bank
//   eoadc_i      one-cycle pulse qualifying adc_data_i
//   adc_data_i   converted sample
//   rd_addr_i    buffer readback address
//   count_row_o  row counter
//   count_col_o  column counter
//   zset_o       settle time elapsed
//   zleds_o      LED time elapsed
//   row_sel_o    one-hot row select (all zero when the row is out of range)
//   col_sel_o    one-hot column select (all zero when the column is out of range)
//   leds_o       LED bank
//   rd_data_o    readback data, one cycle after rd_addr_i
//
// Handshake: eoadc_i is a valid-only strobe. There is no ready; the datapath
// accepts a sample on every cycle where eoadc_i is high.

module nxm_scan_datapath #(
   parameter int N_ROWS    = 2,
   parameter int N_COLS    = 2,
   parameter int CNT_W     = 2,
   parameter int ADC_W     = 12,
   parameter int LED_W     = 8,
   parameter int SET_TICKS = 50000,
   parameter int LED_TICKS = 25000000,
   parameter int TMR_W     = 25,
   parameter int ADDR_W    = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [1:0]        oprow_i,
   input  logic [1:0]        opcol_i,
   input  logic              enset_i,
   input  logic              enleds_i,
   input  logic              eoadc_i,
   input  logic [ADC_W-1:0]  adc_data_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [CNT_W-1:0]  count_row_o,
   output logic [CNT_W-1:0]  count_col_o,
   output logic              zset_o,
   output logic              zleds_o,
   output logic [N_ROWS-1:0] row_sel_o,
   output logic [N_COLS-1:0] col_sel_o,
   output logic [LED_W-1:0]  leds_o,
   output logic [ADC_W-1:0]  rd_data_o
);

   localparam int DEPTH     = N_ROWS * N_COLS;
   localparam int BUF_WORDS = 2 ** ADDR_W;

   localparam logic [TMR_W-1:0] SET_RELOAD = TMR_W'(SET_TICKS - 1);
   localparam logic [TMR_W-1:0] LED_RELOAD = TMR_W'(LED_TICKS - 1);

   logic [CNT_W-1:0]  count_row;
   logic [CNT_W-1:0]  count_col;
   logic [TMR_W-1:0]  set_tmr;
   logic [TMR_W-1:0]  led_tmr;
   // Only the bits that reach the LED bank are kept from the latest sample.
   logic [LED_W-1:0]  led_sample_q;
   logic [ADC_W-1:0]  pix_buf [0:BUF_WORDS-1];
   logic [ADDR_W-1:0] wr_idx;
   logic              wr_in_range;

   // ---------------------------------------------------------------- counters
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_row <= '0;
         count_col <= '0;
      end else begin
         case (oprow_i)
            2'b00:   count_row <= '0;
            2'b10:   count_row <= count_row + 1'b1;
            default: count_row <= count_row;
         endcase
         case (opcol_i)
            2'b00:   count_col <= '0;
            2'b10:   count_col <= count_col + 1'b1;
            default: count_col <= count_col;
         endcase
      end
   end

   assign count_row_o = count_row;
   assign count_col_o = count_col;

   // ----------------------------------------------------------------- selects
   for (genvar i = 0; i < N_ROWS; i++) begin : g_row_sel
      assign row_sel_o[i] = (count_row == CNT_W'(i));
   end
   for (genvar j = 0; j < N_COLS; j++) begin : g_col_sel
      assign col_sel_o[j] = (count_col == CNT_W'(j));
   end

   // ------------------------------------------------------------------ timers
   // Each timer reloads whenever its enable is low, so a one-cycle drop of
   // the enable restarts the full interval.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         set_tmr <= SET_RELOAD;
         led_tmr <= LED_RELOAD;
      end else begin
         if (!enset_i)
            set_tmr <= SET_RELOAD;
         else if (set_tmr != '0)
            set_tmr <= set_tmr - 1'b1;

         if (!enleds_i)
            led_tmr <= LED_RELOAD;
         else if (led_tmr != '0)
            led_tmr <= led_tmr - 1'b1;
      end
   end

   assign zset_o  = enset_i  && (set_tmr == '0);
   assign zleds_o = enleds_i && (led_tmr == '0);

   // ----------------------------------------------------------------- capture
   // The write address uses the counter values before this edge, so an
   // increment issued together with eoadc_i lands the sample at the old pixel.
   // The range check also keeps an out-of-range row from aliasing onto a
   // low address after truncation to ADDR_W bits.
   assign wr_in_range = (int'(count_row) < N_ROWS) && (int'(count_col) < N_COLS);
   assign wr_idx      = ADDR_W'(int'(count_row) * N_COLS + int'(count_col));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         led_sample_q <= '0;
         for (int k = 0; k < BUF_WORDS; k++)
            pix_buf[k] <= '0;
      end else if (eoadc_i) begin
         led_sample_q <= adc_data_i[ADC_W-1 -: LED_W];
         if (wr_in_range)
            pix_buf[wr_idx] <= adc_data_i;
      end
   end

   assign leds_o = enleds_i ? led_sample_q : '0;

   // ---------------------------------------------------------------- readback
   // Reads see the buffer contents from before a same-edge write.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         rd_data_o <= '0;
      else if (int'(rd_addr_i) < DEPTH)
         rd_data_o <= pix_buf[rd_addr_i];
      else
         rd_data_o <= '0;
   end

endmodule

// File: tb/tb_nxm_scan_datapath.sv
// tb_nxm_scan_datapath
//   Directed bench for nxm_scan_datapath with a 2x2 matrix, a 4-cycle settle
//   timer and a 2-cycle LED timer. The scan FSM is emulated by driving the
//   counter opcodes directly.

module tb_nxm_scan_datapath;

   localparam int N_ROWS    = 2;
   localparam int N_COLS    = 2;
   localparam int CNT_W     = 2;
   localparam int ADC_W     = 12;
   localparam int LED_W     = 8;
   localparam int SET_TICKS = 4;
   localparam int LED_TICKS = 2;
   localparam int TMR_W     = 25;
   localparam int ADDR_W    = 2;

   logic              clk_i;
   logic              rst_i;
   logic [1:0]        oprow_i;
   logic [1:0]        opcol_i;
   logic              enset_i;
   logic              enleds_i;
   logic              eoadc_i;
   logic [ADC_W-1:0]  adc_data_i;
   logic [ADDR_W-1:0] rd_addr_i;
   logic [CNT_W-1:0]  count_row_o;
   logic [CNT_W-1:0]  count_col_o;
   logic              zset_o;
   logic              zleds_o;
   logic [N_ROWS-1:0] row_sel_o;
   logic [N_COLS-1:0] col_sel_o;
   logic [LED_W-1:0]  leds_o;
   logic [ADC_W-1:0]  rd_data_o;

   int n_cmp = 0;
   int n_err = 0;
   logic [ADC_W-1:0] exp_q[$];

   nxm_scan_datapath #(
      .N_ROWS(N_ROWS), .N_COLS(N_COLS), .CNT_W(CNT_W), .ADC_W(ADC_W),
      .LED_W(LED_W), .SET_TICKS(SET_TICKS), .LED_TICKS(LED_TICKS),
      .TMR_W(TMR_W), .ADDR_W(ADDR_W)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .oprow_i(oprow_i), .opcol_i(opcol_i),
      .enset_i(enset_i), .enleds_i(enleds_i), .eoadc_i(eoadc_i),
      .adc_data_i(adc_data_i), .rd_addr_i(rd_addr_i),
      .count_row_o(count_row_o), .count_col_o(count_col_o),
      .zset_o(zset_o), .zleds_o(zleds_o), .row_sel_o(row_sel_o),
      .col_sel_o(col_sel_o), .leds_o(leds_o), .rd_data_o(rd_data_o)
   );

   // --------------------------------------------------------- clock / reset
   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // ---------------------------------------------------------- driver tasks
   // Advance one edge; outputs are sampled 1 ns after it.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic ops(input logic [1:0] r, input logic [1:0] c);
      oprow_i = r;
      opcol_i = c;
   endtask

   // ------------------------------------------------------------- stimulus
   initial begin
      logic [ADC_W-1:0] samples [4];
      logic [ADC_W-1:0] exp_word;
      samples[0] = 12'h111;
      samples[1] = 12'h222;
      samples[2] = 12'h333;
      samples[3] = 12'h444;

      rst_i = 1'b1;
      ops(2'b01, 2'b01);
      enset_i = 1'b0; enleds_i = 1'b0; eoadc_i = 1'b0;
      adc_data_i = '0; rd_addr_i = '0;
      step(); step();
      rst_i = 1'b0;
      step();

      // Reset state
      check("rst_row",     count_row_o, 0);
      check("rst_col",     count_col_o, 0);
      check("rst_zset",    zset_o, 0);
      check("rst_zleds",   zleds_o, 0);
      check("rst_row_sel", row_sel_o, 2'b01);
      check("rst_col_sel", col_sel_o, 2'b01);
      check("rst_rd_data", rd_data_o, 0);
      enleds_i = 1'b1; #1;
      check("rst_leds",    leds_o, 0);
      enleds_i = 1'b0;

      // Asynchronous reset in the middle of counting
      ops(2'b10, 2'b10);
      step(); step();
      check("pre_rst_col", count_col_o, 2);
      #2 rst_i = 1'b1;
      #1;
      check("arst_row",     count_row_o, 0);
      check("arst_col",     count_col_o, 0);
      check("arst_row_sel", row_sel_o, 2'b01);
      check("arst_col_sel", col_sel_o, 2'b01);
      check("arst_rd_data", rd_data_o, 0);
      ops(2'b01, 2'b01);
      #2 rst_i = 1'b0;
      step();

      // Column increments, out-of-range selects, wrap, row inc with col clear
      ops(2'b01, 2'b10);
      step(); check("col_1", count_col_o, 1); check("col_sel_1", col_sel_o, 2'b10);
      step(); check("col_2", count_col_o, 2); check("col_sel_2", col_sel_o, 2'b00);
      step(); check("col_3", count_col_o, 3); check("col_sel_3", col_sel_o, 2'b00);
      step(); check("col_wrap", count_col_o, 0); check("col_sel_wrap", col_sel_o, 2'b01);
      ops(2'b10, 2'b00);
      step();
      check("row_inc_row", count_row_o, 1);
      check("row_inc_col", count_col_o, 0);
      check("row_inc_sel", row_sel_o, 2'b10);
      ops(2'b01, 2'b01);

      // Settle timer: zset on the 4th consecutive enable cycle
      enset_i = 1'b1; #1;
      check("zset_c1", zset_o, 0);
      step(); check("zset_c2", zset_o, 0);
      step(); check("zset_c3", zset_o, 0);
      step(); check("zset_c4", zset_o, 1);
      step(); check("zset_c5", zset_o, 1);
      enset_i = 1'b0; #1;
      check("zset_off", zset_o, 0);
      step();
      enset_i = 1'b1; #1;
      check("zset_r1", zset_o, 0);
      step(); step(); check("zset_r3", zset_o, 0);
      step(); check("zset_r4", zset_o, 1);
      enset_i = 1'b0;

      // Capture at (1,0) into word 2; same-edge read returns the old word
      rd_addr_i = 2'd2;
      eoadc_i = 1'b1; adc_data_i = 12'hABC;
      step();
      eoadc_i = 1'b0;
      check("rd_same_edge", rd_data_o, 0);
      step();
      check("rd_word2", rd_data_o, 12'hABC);
      enleds_i = 1'b1; #1;
      check("leds_ab", leds_o, 8'hAB);
      check("zleds_c1", zleds_o, 0);
      step();
      check("zleds_c2", zleds_o, 1);
      enleds_i = 1'b0; #1;
      check("leds_gated", leds_o, 0);
      check("zleds_off", zleds_o, 0);

      // Out-of-range row: no write, sample still updates
      ops(2'b10, 2'b01);
      step();
      ops(2'b01, 2'b01);
      check("row_2", count_row_o, 2);
      check("row_sel_2", row_sel_o, 2'b00);
      rd_addr_i = 2'd0;
      eoadc_i = 1'b1; adc_data_i = 12'h5A7;
      step();
      eoadc_i = 1'b0;
      step();
      check("oor_word0", rd_data_o, 0);
      rd_addr_i = 2'd2;
      step();
      check("oor_word2", rd_data_o, 12'hABC);
      enleds_i = 1'b1; #1;
      check("oor_leds", leds_o, 8'h5A);
      enleds_i = 1'b0;

      // Capture with a same-edge column increment lands at the old column
      ops(2'b00, 2'b00);
      step();
      ops(2'b01, 2'b10);
      eoadc_i = 1'b1; adc_data_i = 12'h3C4;
      step();
      ops(2'b01, 2'b01);
      eoadc_i = 1'b0;
      check("inc_cap_col", count_col_o, 1);
      rd_addr_i = 2'd0; step();
      check("inc_cap_w0", rd_data_o, 12'h3C4);
      rd_addr_i = 2'd1; step();
      check("inc_cap_w1", rd_data_o, 0);

      // Full 2x2 scan driven as the scan FSM would
      ops(2'b00, 2'b00);
      step();
      for (int r = 0; r < N_ROWS; r++) begin
         for (int c = 0; c < N_COLS; c++) begin
            check("scan_row", count_row_o, r);
            check("scan_col", count_col_o, c);
            check("scan_row_sel", row_sel_o, 32'(1) << r);
            check("scan_col_sel", col_sel_o, 32'(1) << c);
            eoadc_i = 1'b1;
            adc_data_i = samples[r * N_COLS + c];
            exp_q.push_back(samples[r * N_COLS + c]);
            ops(2'b01, 2'b10);
            step();
            eoadc_i = 1'b0;
            ops(2'b01, 2'b01);
         end
         check("scan_eor", count_col_o, N_COLS);
         ops(2'b10, 2'b00);
         step();
         ops(2'b01, 2'b01);
      end
      check("scan_eos", count_row_o, N_ROWS);

      // Scoreboard drain: words come back in scan order
      for (int a = 0; a < N_ROWS * N_COLS; a++) begin
         rd_addr_i = ADDR_W'(a);
         step();
         exp_word = exp_q.pop_front();
         check("scan_rd", rd_data_o, exp_word);
      end
      check("scan_q_empty", exp_q.size(), 0);

      // ---------------------------------------------------------- report
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
